cpc_ram_arbiter: RTL and testbench
==================================

// Module: cpc_ram_arbiter
// PURPOSE
// Shares the single 8-bit main RAM port between three requesters: video fetch (16-bit words for the Gate Array),
// ROM/disk loader writes, and Z80 memory cycles. Sequences the RAM strobes and absorbs fixed read latency.
// Returns single-cycle acks to each requester. Sits between the motherboard/MMU and the SDRAM/BRAM controller.
// PARAMETERS
// AW        23       RAM byte-address width
// RD_LAT    2        clocks from ram_rd pulse to valid ram_din (1..7)
// VID_BASE  23'h0    byte base of video bank; video byte address = VID_BASE + {vid_addr,b}, b=0 lo, b=1 hi
// PORTS
// clk       in   1    system clock, all logic rising-edge
// reset_n   in   1    asynchronous active-low reset
// vid_req   in   1    video word request, level, held until vid_ack
// vid_addr  in   15   video word address
// vid_dout  out  16   {hi,lo} fetched word, valid when vid_ack=1, held until next vid_ack
// vid_ack   out  1    1-clk pulse: word available
// ldr_wr    in   1    loader write request, level, held until ldr_ack
// ldr_addr  in   AW   loader byte address
// ldr_data  in   8    loader write data
// ldr_ack   out  1    1-clk pulse: write issued
// cpu_rd    in   1    CPU read request, level, held until cpu_ack
// cpu_wr    in   1    CPU write request, level, held until cpu_ack
// cpu_addr  in   AW   CPU byte address (from MMU)
// cpu_din   in   8    CPU write data
// cpu_dout  out  8    read data, valid at cpu_ack, held until next CPU read completes
// cpu_ack   out  1    1-clk pulse: access complete
// cpu_wait  out  1    1 while CPU request pending and not yet acked (drives Z80 wait)
// ram_addr  out  AW   RAM byte address
// ram_dout  out  8    RAM write data
// ram_din   in   8    RAM read data
// ram_rd    out  1    1-clk read strobe
// ram_wr    out  1    1-clk write strobe
// BEHAVIOUR
// - Reset (async, reset_n=0): state IDLE; all acks, ram_rd, ram_wr, cpu_wait = 0; vid_dout=0, cpu_dout=0, ram_addr=0.
// - Reset mid-operation: in-flight read data discarded, no ack issued; requesters must re-present after release.
// - FSM states: IDLE, V_LO, V_HI, V_WAIT, L_WR, C_RD, C_WR, C_WAIT.
// - IDLE grant priority: vid_req > ldr_wr > cpu, except fairness flag: after a completed video word, if a CPU
//   request is pending, next grant goes to CPU (flag cleared on CPU grant or when no CPU request).
// - V_LO: ram_rd=1, ram_addr=VID_BASE+{vid_addr,0}; -> V_HI. V_HI: ram_rd=1, addr +1; -> V_WAIT.
//   V_WAIT: capture lo at RD_LAT after V_LO strobe, hi at RD_LAT after V_HI strobe; after hi capture -> vid_ack
//   pulse with vid_dout updated same edge, -> IDLE. Video word latency = RD_LAT+2 clks from grant.
// - L_WR: ram_wr=1, ram_addr=ldr_addr, ram_dout=ldr_data, ldr_ack=1 same cycle; -> IDLE.
// - C_WR: ram_wr=1, cpu_ack=1 same cycle; -> IDLE. C_RD: ram_rd=1; -> C_WAIT; capture ram_din RD_LAT clks
//   after strobe into cpu_dout, cpu_ack pulse same edge; -> IDLE.
// - cpu_rd and cpu_wr both 1: treated as write. Request dropped before grant: no access, no ack.
// - cpu_wait = (cpu_rd|cpu_wr) & ~cpu_ack, combinational.
// - Only one access outstanding at a time; no new grant until current state returns to IDLE.
// - Address arithmetic VID_BASE+{vid_addr,b} is modulo 2^AW (wraps silently).
// - Requester seeing ack must deassert or present a new request next clock; a held request re-arbitrates.
// CONFIGURATION
// ARB_STALL_CNT_EN: when defined, adds output cpu_stall_cnt[15:0]: counts clocks with cpu_wait=1, saturates at
// 16'hFFFF, cleared by reset only. When undefined, port and counter absent; all other behaviour identical.
// TESTING
// 1 Reset: hold reset_n=0 with all reqs high -> all strobes/acks 0; release -> first grant video (priority).
// 2 Video fetch RD_LAT=2, vid_addr=15'h0123, RAM[246]=8'hAA, RAM[247]=8'h55 -> ram_rd at 246 then 247,
//   vid_ack 4 clks after grant, vid_dout=16'h55AA.
// 3 vid_req and cpu_rd held continuously -> grants alternate video,CPU,video; cpu_ack every cycle-group, no starvation.
// 4 cpu_wr addr 23'h4000 data 8'h3C -> ram_wr 1 clk, cpu_ack same clk; then cpu_rd 23'h4000 -> cpu_dout=8'h3C
//   after RD_LAT+1 clks, cpu_wait high until ack.
// 5 Loader vs CPU simultaneous (no video) -> ldr_ack first, CPU next; reset_n pulse during C_WAIT -> no cpu_ack.
// 6 ARB_STALL_CNT_EN: CPU blocked 5 clks by video -> cpu_stall_cnt=5; force >65535 stall clks -> holds 16'hFFFF.

Source files
------------

// File: rtl/cpc_ram_arbiter.sv
// cpc_ram_arbiter
//
// Shares the single 8-bit main RAM port between three requesters:
//   - video fetch: 16-bit words for the Gate Array, built from two byte reads
//   - loader:      ROM/disk image byte writes
//   - CPU:         Z80 memory reads and writes (after the MMU)
// Sequences the RAM strobes, absorbs the fixed RAM read latency and returns
// one-clock acks to each requester. Only one access is in flight at a time.
//
// Parameters
//   AW        RAM byte-address width
//   RD_LAT    clocks from a ram_rd strobe to valid ram_din (1..7)
//   VID_BASE  byte base of the video bank
//
// Ports
//   clk, reset_n                     clock, asynchronous active-low reset
//   vid_req/vid_addr/vid_dout/vid_ack  video word request, word address, {hi,lo} data, ack
//   ldr_wr/ldr_addr/ldr_data/ldr_ack   loader byte write request, address, data, ack
//   cpu_rd/cpu_wr/cpu_addr/cpu_din     CPU request, byte address, write data
//   cpu_dout/cpu_ack/cpu_wait          CPU read data, ack, Z80 wait
//   ram_addr/ram_dout/ram_din          RAM byte address, write data, read data
//   ram_rd/ram_wr                      one-clock RAM read / write strobes
//
// Optional feature (macro ARB_STALL_CNT_EN)
//   Adds output cpu_stall_cnt[15:0]: number of clocks with cpu_wait=1,
//   saturating at 16'hFFFF, cleared only by reset.

module cpc_ram_arbiter #(
  parameter int unsigned   AW       = 23,
  parameter int unsigned   RD_LAT   = 2,
  parameter logic [AW-1:0] VID_BASE = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [14:0]   vid_addr,
  output logic [15:0]   vid_dout,
  output logic          vid_ack,
  input  logic          ldr_wr,
  input  logic [AW-1:0] ldr_addr,
  input  logic [7:0]    ldr_data,
  output logic          ldr_ack,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  output logic          cpu_wait,
`ifdef ARB_STALL_CNT_EN
  output logic [15:0]   cpu_stall_cnt,
`endif
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_dout,
  input  logic [7:0]    ram_din,
  output logic          ram_rd,
  output logic          ram_wr
);

  typedef enum logic [2:0] {
    StIdle, StVLo, StVHi, StVWait, StLWr, StCRd, StCWr, StCWait
  } state_e;

  // cnt_q counts clocks since the first strobe of the current access, so a
  // byte strobed at cnt=k is valid on ram_din while cnt=k+RD_LAT.
  localparam logic [3:0] LoCap = 4'(RD_LAT);
  localparam logic [3:0] HiCap = 4'(RD_LAT + 1);
  localparam logic [3:0] CpuCap = 4'(RD_LAT);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    vid_lo_q, vid_lo_d;
  logic [15:0]   vid_dout_q, vid_dout_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          vid_ack_q, vid_ack_d;
  logic          cpu_rd_ack_q, cpu_rd_ack_d;
  logic          fair_q, fair_d;

  logic          cpu_req;
  logic          vid_eff;
  logic          cpu_eff;
  logic [AW-1:0] vid_lo_addr;

  assign cpu_req     = cpu_rd | cpu_wr;
  // Registered acks land in the IDLE cycle that follows completion; the
  // requester still holds its request then, so mask it to avoid a duplicate.
  assign vid_eff     = vid_req & ~vid_ack_q;
  assign cpu_eff     = cpu_req & ~cpu_rd_ack_q;
  // Modulo 2^AW: the carry out of the top bit is simply dropped.
  assign vid_lo_addr = VID_BASE + AW'({vid_addr, 1'b0});

  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    vid_lo_d     = vid_lo_q;
    vid_dout_d   = vid_dout_q;
    cpu_dout_d   = cpu_dout_q;
    vid_ack_d    = 1'b0;
    cpu_rd_ack_d = 1'b0;
    fair_d       = fair_q;

    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        // Fairness is consumed by a CPU grant, or dropped when no CPU request
        // is pending; either way it never survives an IDLE cycle.
        fair_d = 1'b0;
        if (fair_q && cpu_eff) begin
          state_d = cpu_wr ? StCWr : StCRd;
        end else if (vid_eff) begin
          state_d = StVLo;
        end else if (ldr_wr) begin
          state_d = StLWr;
        end else if (cpu_eff) begin
          state_d = cpu_wr ? StCWr : StCRd;
        end
      end
      StVLo: begin
        state_d = StVHi;
      end
      StVHi: begin
        // With RD_LAT=1 the low byte arrives while the high byte is strobed.
        if (cnt_q == LoCap) vid_lo_d = ram_din;
        state_d = StVWait;
      end
      StVWait: begin
        if (cnt_q == LoCap) vid_lo_d = ram_din;
        if (cnt_q == HiCap) begin
          vid_dout_d = {ram_din, vid_lo_q};
          vid_ack_d  = 1'b1;
          fair_d     = 1'b1;
          state_d    = StIdle;
        end
      end
      StLWr: begin
        state_d = StIdle;
      end
      StCWr: begin
        state_d = StIdle;
      end
      StCRd: begin
        state_d = StCWait;
      end
      StCWait: begin
        if (cnt_q == CpuCap) begin
          cpu_dout_d   = ram_din;
          cpu_rd_ack_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      vid_lo_q     <= '0;
      vid_dout_q   <= '0;
      cpu_dout_q   <= '0;
      vid_ack_q    <= 1'b0;
      cpu_rd_ack_q <= 1'b0;
      fair_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vid_lo_q     <= vid_lo_d;
      vid_dout_q   <= vid_dout_d;
      cpu_dout_q   <= cpu_dout_d;
      vid_ack_q    <= vid_ack_d;
      cpu_rd_ack_q <= cpu_rd_ack_d;
      fair_q       <= fair_d;
    end
  end

  // RAM strobes and address are decoded straight from the state; requesters
  // hold address/data stable until acked.
  always_comb begin
    ram_addr = '0;
    ram_dout = '0;
    ram_rd   = 1'b0;
    ram_wr   = 1'b0;
    unique case (state_q)
      StVLo: begin
        ram_rd   = 1'b1;
        ram_addr = vid_lo_addr;
      end
      StVHi: begin
        ram_rd   = 1'b1;
        ram_addr = vid_lo_addr + AW'(1);
      end
      StLWr: begin
        ram_wr   = 1'b1;
        ram_addr = ldr_addr;
        ram_dout = ldr_data;
      end
      StCRd: begin
        ram_rd   = 1'b1;
        ram_addr = cpu_addr;
      end
      StCWr: begin
        ram_wr   = 1'b1;
        ram_addr = cpu_addr;
        ram_dout = cpu_din;
      end
      default: ;
    endcase
  end

  assign vid_dout = vid_dout_q;
  assign vid_ack  = vid_ack_q;
  assign ldr_ack  = (state_q == StLWr);
  assign cpu_dout = cpu_dout_q;
  assign cpu_ack  = cpu_rd_ack_q | (state_q == StCWr);
  // Gated by reset so the Z80 is not held in wait while the arbiter is reset.
  assign cpu_wait = reset_n & cpu_req & ~cpu_ack;

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (cpu_wait && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign cpu_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cpc_ram_arbiter.sv
module tb_cpc_ram_arbiter;

  localparam int unsigned AW     = 23;
  localparam int unsigned RD_LAT = 2;

  logic          clk;
  logic          reset_n;
  logic          vid_req;
  logic [14:0]   vid_addr;
  logic [15:0]   vid_dout;
  logic          vid_ack;
  logic          ldr_wr;
  logic [AW-1:0] ldr_addr;
  logic [7:0]    ldr_data;
  logic          ldr_ack;
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;
  logic          cpu_wait;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;
  logic          ram_rd;
  logic          ram_wr;
`ifdef ARB_STALL_CNT_EN
  logic [15:0]   cpu_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Scoreboards of expected read data, pushed at grant, popped at ack.
  logic [15:0] vid_q[$];
  logic [7:0]  cpu_q[$];
  // Bench's own view of memory contents, updated when it issues writes.
  logic [7:0]  exp_mem [0:65535];

  cpc_ram_arbiter #(
    .AW     (AW),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_dout (vid_dout),
    .vid_ack  (vid_ack),
    .ldr_wr   (ldr_wr),
    .ldr_addr (ldr_addr),
    .ldr_data (ldr_data),
    .ldr_ack  (ldr_ack),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_ack  (cpu_ack),
    .cpu_wait (cpu_wait),
`ifdef ARB_STALL_CNT_EN
    .cpu_stall_cnt (cpu_stall_cnt),
`endif
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .ram_din  (ram_din),
    .ram_rd   (ram_rd),
    .ram_wr   (ram_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: byte strobed in cycle t appears on ram_din in cycle t+RD_LAT.
  logic [7:0] ram_mem [0:65535];
  logic [7:0] rd_pipe [0:RD_LAT-1];

  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_addr[15:0]] <= ram_dout;
    rd_pipe[0] <= ram_rd ? ram_mem[ram_addr[15:0]] : 8'h00;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_din = rd_pipe[RD_LAT-1];

  task automatic test_reset();
    int n;
    reset_n  = 1'b0;
    vid_req  = 1'b1;
    ldr_wr   = 1'b1;
    cpu_rd   = 1'b1;
    vid_addr = 15'h0010;
    ldr_addr = 23'h000300;
    cpu_addr = 23'h000400;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_rd, ram_wr, vid_ack, ldr_ack, cpu_ack, cpu_wait} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 000000",
               {ram_rd, ram_wr, vid_ack, ldr_ack, cpu_ack, cpu_wait});
    end
    checks++;
    if (vid_dout !== 16'h0 || cpu_dout !== 8'h0 || ram_addr !== 23'h0) begin
      errors++;
      $display("FAIL reset_data: vid_dout=%h cpu_dout=%h ram_addr=%h want 0/0/0",
               vid_dout, cpu_dout, ram_addr);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ram_rd !== 1'b1 || ram_addr !== 23'h000020) begin
      errors++;
      $display("FAIL reset_first_grant: ram_rd=%b addr=%h want 1/000020", ram_rd, ram_addr);
    end
    ldr_wr = 1'b0;
    cpu_rd = 1'b0;
    n = 0;
    while (vid_ack !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (vid_ack !== 1'b1) begin
      errors++;
      $display("FAIL reset_vid_ack: vid_ack=%b want 1 within 20 clks", vid_ack);
    end
    vid_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loader();
    logic [AW-1:0] la [3];
    logic [7:0]    ld [3];
    la = '{23'h000246, 23'h000247, 23'h000100};
    ld = '{8'hAA, 8'h55, 8'h11};
    for (int i = 0; i < 3; i++) begin
      ldr_addr = la[i];
      ldr_data = ld[i];
      ldr_wr   = 1'b1;
      @(negedge clk);
      checks++;
      if ({ram_wr, ldr_ack} !== 2'b11 || ram_addr !== la[i] || ram_dout !== ld[i]) begin
        errors++;
        $display("FAIL loader_wr: wr/ack=%b addr=%h data=%h want 11/%h/%h",
                 {ram_wr, ldr_ack}, ram_addr, ram_dout, la[i], ld[i]);
      end
      exp_mem[la[i][15:0]] = ld[i];
      ldr_wr = 1'b0;
      @(negedge clk);
      checks++;
      if ({ram_wr, ldr_ack} !== 2'b00) begin
        errors++;
        $display("FAIL loader_pulse: wr/ack=%b want 00", {ram_wr, ldr_ack});
      end
    end
  endtask

  task automatic test_video();
    int lat;
    logic [15:0] exp;
    vid_addr = 15'h0123;
    vid_req  = 1'b1;
    vid_q.push_back({exp_mem[16'h0247], exp_mem[16'h0246]});
    @(negedge clk);
    checks++;
    if (ram_rd !== 1'b1 || ram_addr !== 23'h000246) begin
      errors++;
      $display("FAIL video_lo_strobe: ram_rd=%b addr=%h want 1/000246", ram_rd, ram_addr);
    end
    @(negedge clk);
    checks++;
    if (ram_rd !== 1'b1 || ram_addr !== 23'h000247) begin
      errors++;
      $display("FAIL video_hi_strobe: ram_rd=%b addr=%h want 1/000247", ram_rd, ram_addr);
    end
    lat = 1;
    while (vid_ack !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != RD_LAT + 2) begin
      errors++;
      $display("FAIL video_latency: got %0d clks want %0d", lat, RD_LAT + 2);
    end
    exp = vid_q.pop_front();
    checks++;
    if (vid_dout !== exp) begin
      errors++;
      $display("FAIL video_data: got %h want %h", vid_dout, exp);
    end
    vid_req = 1'b0;
    @(negedge clk);
    checks++;
    if (vid_ack !== 1'b0 || ram_rd !== 1'b0 || vid_dout !== exp) begin
      errors++;
      $display("FAIL video_after_ack: ack=%b rd=%b dout=%h want 0/0/%h",
               vid_ack, ram_rd, vid_dout, exp);
    end
  endtask

  task automatic test_cpu_wr_rd();
    int lat;
    bit wait_bad;
    logic [7:0] exp;
    cpu_addr = 23'h004000;
    cpu_din  = 8'h3C;
    cpu_wr   = 1'b1;
    #1;
    checks++;
    if (cpu_wait !== 1'b1) begin
      errors++;
      $display("FAIL cpu_wr_wait: cpu_wait=%b want 1", cpu_wait);
    end
    @(negedge clk);
    checks++;
    if ({ram_wr, cpu_ack, cpu_wait} !== 3'b110 || ram_addr !== 23'h004000 ||
        ram_dout !== 8'h3C) begin
      errors++;
      $display("FAIL cpu_wr: wr/ack/wait=%b addr=%h data=%h want 110/004000/3c",
               {ram_wr, cpu_ack, cpu_wait}, ram_addr, ram_dout);
    end
    exp_mem[16'h4000] = 8'h3C;
    cpu_wr = 1'b0;
    @(negedge clk);
    cpu_rd = 1'b1;
    cpu_q.push_back(exp_mem[16'h4000]);
    @(negedge clk);
    checks++;
    if (ram_rd !== 1'b1 || ram_addr !== 23'h004000) begin
      errors++;
      $display("FAIL cpu_rd_strobe: ram_rd=%b addr=%h want 1/004000", ram_rd, ram_addr);
    end
    lat = 0;
    wait_bad = 1'b0;
    while (cpu_ack !== 1'b1 && lat < 20) begin
      if (cpu_wait !== 1'b1) wait_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != RD_LAT + 1) begin
      errors++;
      $display("FAIL cpu_rd_latency: got %0d clks want %0d", lat, RD_LAT + 1);
    end
    checks++;
    if (wait_bad || cpu_wait !== 1'b0) begin
      errors++;
      $display("FAIL cpu_rd_wait: dropped_early=%b at_ack=%b want 0/0", wait_bad, cpu_wait);
    end
    exp = cpu_q.pop_front();
    checks++;
    if (cpu_dout !== exp) begin
      errors++;
      $display("FAIL cpu_rd_data: got %h want %h", cpu_dout, exp);
    end
    cpu_rd = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0 || cpu_dout !== exp) begin
      errors++;
      $display("FAIL cpu_rd_hold: ack=%b dout=%h want 0/%h", cpu_ack, cpu_dout, exp);
    end
  endtask

  task automatic test_fairness();
    int grants[$];
    int cpu_acks;
    logic [15:0] ev;
    logic [7:0]  ec;
    vid_addr = 15'h0123;
    cpu_addr = 23'h004000;
    vid_req  = 1'b1;
    cpu_rd   = 1'b1;
    cpu_acks = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (ram_rd === 1'b1 && ram_addr === 23'h000246) begin
        grants.push_back(0);
        vid_q.push_back({exp_mem[16'h0247], exp_mem[16'h0246]});
      end
      if (ram_rd === 1'b1 && ram_addr === 23'h004000) begin
        grants.push_back(1);
        cpu_q.push_back(exp_mem[16'h4000]);
      end
      if (vid_ack === 1'b1 && vid_q.size() > 0) begin
        ev = vid_q.pop_front();
        checks++;
        if (vid_dout !== ev) begin
          errors++;
          $display("FAIL fair_vid_data: got %h want %h", vid_dout, ev);
        end
      end
      if (cpu_ack === 1'b1 && cpu_q.size() > 0) begin
        ec = cpu_q.pop_front();
        cpu_acks++;
        checks++;
        if (cpu_dout !== ec) begin
          errors++;
          $display("FAIL fair_cpu_data: got %h want %h", cpu_dout, ec);
        end
      end
      if (cyc == 40) begin
        vid_req = 1'b0;
        cpu_rd  = 1'b0;
      end
    end
    checks++;
    if (grants.size() < 4 || cpu_acks < 2) begin
      errors++;
      $display("FAIL fair_progress: grants=%0d cpu_acks=%0d want >=4/>=2",
               grants.size(), cpu_acks);
    end
    for (int i = 0; i < grants.size() && i < 4; i++) begin
      checks++;
      if (grants[i] != (i % 2)) begin
        errors++;
        $display("FAIL fair_order: grant %0d is %0d want %0d (0=video 1=cpu)",
                 i, grants[i], i % 2);
      end
    end
    checks++;
    if (vid_q.size() != 0 || cpu_q.size() != 0) begin
      errors++;
      $display("FAIL fair_drain: pending vid=%0d cpu=%0d want 0/0", vid_q.size(), cpu_q.size());
    end
  endtask

  task automatic test_drop();
    int n;
    bit bad;
    logic [15:0] ev;
    vid_addr = 15'h0123;
    vid_req  = 1'b1;
    vid_q.push_back({exp_mem[16'h0247], exp_mem[16'h0246]});
    @(negedge clk);
    cpu_addr = 23'h000200;
    cpu_din  = 8'h99;
    cpu_wr   = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0;
    bad = 1'b0;
    n = 0;
    while (n < 12) begin
      if (ram_wr === 1'b1 || cpu_ack === 1'b1) bad = 1'b1;
      if (vid_ack === 1'b1) begin
        ev = vid_q.pop_front();
        checks++;
        if (vid_dout !== ev) begin
          errors++;
          $display("FAIL drop_vid_data: got %h want %h", vid_dout, ev);
        end
        vid_req = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (bad || vid_q.size() != 0) begin
      errors++;
      $display("FAIL drop_no_access: cpu_access=%b vid_pending=%0d want 0/0", bad, vid_q.size());
    end
  endtask

  task automatic test_ldr_vs_cpu();
    int ldr_cyc;
    int cpu_cyc;
    ldr_addr = 23'h000100;
    ldr_data = 8'h77;
    ldr_wr   = 1'b1;
    cpu_addr = 23'h000101;
    cpu_din  = 8'h88;
    cpu_wr   = 1'b1;
    ldr_cyc  = -1;
    cpu_cyc  = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ldr_ack === 1'b1 && ldr_cyc < 0) begin
        ldr_cyc = n;
        ldr_wr = 1'b0;
        exp_mem[16'h0100] = 8'h77;
      end
      if (cpu_ack === 1'b1 && cpu_cyc < 0) begin
        cpu_cyc = n;
        cpu_wr = 1'b0;
        exp_mem[16'h0101] = 8'h88;
      end
    end
    checks++;
    if (ldr_cyc != 1 || cpu_cyc != 3) begin
      errors++;
      $display("FAIL ldr_vs_cpu: ldr_ack at %0d cpu_ack at %0d want 1/3", ldr_cyc, cpu_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    int n;
    logic [7:0] ec;
    cpu_addr = 23'h000100;
    cpu_rd   = 1'b1;
    @(negedge clk);
    checks++;
    if (ram_rd !== 1'b1 || ram_addr !== 23'h000100) begin
      errors++;
      $display("FAIL mid_rd_strobe: ram_rd=%b addr=%h want 1/000100", ram_rd, ram_addr);
    end
    @(negedge clk);
    reset_n = 1'b0;
    cpu_rd  = 1'b0;
    #1;
    checks++;
    if ({cpu_ack, ram_rd, cpu_wait} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_outputs: ack/rd/wait=%b want 000", {cpu_ack, ram_rd, cpu_wait});
    end
    @(negedge clk);
    reset_n = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL mid_no_ack: got %0d cpu_acks want 0", acks);
    end
    cpu_rd = 1'b1;
    cpu_q.push_back(exp_mem[16'h0100]);
    n = 0;
    while (cpu_ack !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ec = cpu_q.pop_front();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_dout !== ec) begin
      errors++;
      $display("FAIL mid_represent: ack=%b dout=%h want 1/%h", cpu_ack, cpu_dout, ec);
    end
    cpu_rd = 1'b0;
    @(negedge clk);
  endtask

`ifdef ARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    int n;
    bit done;
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL stall_reset: got %h want 0000", cpu_stall_cnt);
    end
    reset_n  = 1'b1;
    vid_addr = 15'h0123;
    cpu_addr = 23'h004000;
    vid_req  = 1'b1;
    cpu_rd   = 1'b1;
    done = 1'b0;
    for (n = 0; n < 30 && !done; n++) begin
      @(negedge clk);
      if (vid_ack === 1'b1) vid_req = 1'b0;
      if (cpu_ack === 1'b1) begin
        cpu_rd = 1'b0;
        done = 1'b1;
      end
    end
    checks++;
    if (cpu_stall_cnt !== 16'(2 * RD_LAT + 5)) begin
      errors++;
      $display("FAIL stall_count: got %0d want %0d", cpu_stall_cnt, 2 * RD_LAT + 5);
    end
    // A continuously held loader write starves the CPU indefinitely.
    ldr_addr = 23'h000300;
    ldr_data = 8'h00;
    ldr_wr   = 1'b1;
    cpu_rd   = 1'b1;
    repeat (65545) @(negedge clk);
    checks++;
    if (cpu_stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL stall_saturate: got %h want ffff", cpu_stall_cnt);
    end
    ldr_wr = 1'b0;
    cpu_rd = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    reset_n  = 1'b0;
    vid_req  = 1'b0;
    vid_addr = '0;
    ldr_wr   = 1'b0;
    ldr_addr = '0;
    ldr_data = '0;
    cpu_rd   = 1'b0;
    cpu_wr   = 1'b0;
    cpu_addr = '0;
    cpu_din  = '0;
    @(negedge clk);
    test_reset();
    test_loader();
    test_video();
    test_cpu_wr_rd();
    test_fairness();
    test_drop();
    test_ldr_vs_cpu();
    test_reset_mid();
`ifdef ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
